// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Hazard controller for a 5-stage in-order pipeline
//               (F/D/E/M/W). It tracks a small tag per E, M and W stage and
//               decides, every cycle, whether to freeze the whole pipe on a
//               slow data-memory access, squash on a taken branch, insert a
//               bubble for a RAW hazard, or let everything advance. It also
//               selects the execute-stage operand forwarding sources and
//               keeps saturating stall/flush performance counters.
//
// Parameters  : FWD_EN  1 = EX/WB forwarding, 0 = stall-only interlock
//               CNT_W   width of the stall and flush counters
//
// Ports       : clk, reset                   clock, sync active-high reset
//               d_valid_i                    decode holds a real instruction
//               d_rs1_i/d_rs2_i              decode source registers
//               d_rs1_used_i/d_rs2_used_i    decode reads that source
//               d_rd_i                       decode destination register
//               d_regwren_i/d_memren_i/
//               d_memwren_i                  decode reg-write/load/store
//               e_brtaken_i                  E instruction redirects the PC
//               dmem_ready_i                 M-stage memory access completes
//               stall_f_o/stall_d_o          hold PC and decode register
//               flush_d_o/flush_e_o          squash decode / bubble into E
//               fwd_rs1_o/fwd_rs2_o          E operand source select
//               stall_cnt_o/flush_cnt_o      performance counters
//
// Revision    : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             d_valid_i,
    input  logic [4:0]       d_rs1_i,
    input  logic [4:0]       d_rs2_i,
    input  logic             d_rs1_used_i,
    input  logic             d_rs2_used_i,
    input  logic [4:0]       d_rd_i,
    input  logic             d_regwren_i,
    input  logic             d_memren_i,
    input  logic             d_memwren_i,

    input  logic             e_brtaken_i,
    input  logic             dmem_ready_i,

    output logic             stall_f_o,
    output logic             stall_d_o,
    output logic             flush_d_o,
    output logic             flush_e_o,
    output logic [1:0]       fwd_rs1_o,
    output logic [1:0]       fwd_rs2_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0]       c_FWD_RF  = 2'b00;  // register file
    localparam logic [1:0]       c_FWD_MEM = 2'b01;  // M-stage ALU result
    localparam logic [1:0]       c_FWD_WB  = 2'b10;  // writeback data
    localparam logic             c_FWD_ON  = (FWD_EN != 0);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    // ------------------------------------------------------------------------
    // Stage tags
    // ------------------------------------------------------------------------
    // Execute stage: full tag including the sources it consumes
    logic       r_e_valid;
    logic [4:0] r_e_rd;
    logic       r_e_regwren;
    logic       r_e_memren;
    logic       r_e_memwren;
    logic [4:0] r_e_rs1;
    logic [4:0] r_e_rs2;
    logic       r_e_rs1_used;
    logic       r_e_rs2_used;

    // Memory stage
    logic       r_m_valid;
    logic [4:0] r_m_rd;
    logic       r_m_regwren;
    logic       r_m_memren;
    logic       r_m_memwren;

    // Writeback stage
    logic       r_w_valid;
    logic [4:0] r_w_rd;
    logic       r_w_regwren;
    logic       r_w_memren;
    logic       r_w_memwren;

    // Performance counters
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // ------------------------------------------------------------------------
    // Source/producer match. x0 is hardwired to zero, so a producer with
    // rd == 0 never creates a dependency.
    // ------------------------------------------------------------------------
    function automatic logic f_src_match(
        input logic       cons_valid,
        input logic       src_used,
        input logic [4:0] src,
        input logic       prod_valid,
        input logic       prod_regwren,
        input logic [4:0] prod_rd
    );
        f_src_match = cons_valid && src_used && prod_valid && prod_regwren &&
                      (prod_rd != 5'd0) && (prod_rd == src);
    endfunction

    // ------------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------------
    logic w_freeze;
    logic w_br_flush;
    logic w_raw_stall;
    logic w_raw_act;
    logic w_d_rs1_hit_e;
    logic w_d_rs2_hit_e;
    logic w_d_rs1_hit_m;
    logic w_d_rs2_hit_m;
    logic w_hit_e;
    logic w_hit_m;

    always_comb begin
        w_d_rs1_hit_e = f_src_match(d_valid_i, d_rs1_used_i, d_rs1_i,
                                    r_e_valid, r_e_regwren, r_e_rd);
        w_d_rs2_hit_e = f_src_match(d_valid_i, d_rs2_used_i, d_rs2_i,
                                    r_e_valid, r_e_regwren, r_e_rd);
        w_d_rs1_hit_m = f_src_match(d_valid_i, d_rs1_used_i, d_rs1_i,
                                    r_m_valid, r_m_regwren, r_m_rd);
        w_d_rs2_hit_m = f_src_match(d_valid_i, d_rs2_used_i, d_rs2_i,
                                    r_m_valid, r_m_regwren, r_m_rd);
        w_hit_e = w_d_rs1_hit_e | w_d_rs2_hit_e;
        w_hit_m = w_d_rs1_hit_m | w_d_rs2_hit_m;

        // With forwarding only a load in E cannot be bypassed in time.
        // Without it, any producer still in E or M must drain; W is safe
        // because the register file writes before it is read.
        if (c_FWD_ON) begin
            w_raw_stall = w_hit_e & r_e_memren;
        end else begin
            w_raw_stall = w_hit_e | w_hit_m;
        end

        // A slow memory access freezes everything, including a pending
        // branch in E: it is simply re-evaluated once the freeze lifts.
        w_freeze   = r_m_valid & (r_m_memren | r_m_memwren) & ~dmem_ready_i;
        w_br_flush = ~w_freeze & r_e_valid & e_brtaken_i;
        w_raw_act  = ~w_freeze & ~w_br_flush & w_raw_stall;
    end

    // ------------------------------------------------------------------------
    // Pipeline control outputs
    // ------------------------------------------------------------------------
    always_comb begin
        stall_f_o = w_freeze | w_raw_act;
        stall_d_o = w_freeze | w_raw_act;
        flush_d_o = w_br_flush;
        flush_e_o = w_br_flush | w_raw_act;
    end

    // ------------------------------------------------------------------------
    // Forwarding select: purely a function of the registered tags, so it
    // naturally holds its value while the pipe is frozen. M is the younger
    // producer and wins over W.
    // ------------------------------------------------------------------------
    logic w_e1_hit_m;
    logic w_e2_hit_m;
    logic w_e1_hit_w;
    logic w_e2_hit_w;

    always_comb begin
        w_e1_hit_m = f_src_match(r_e_valid, r_e_rs1_used, r_e_rs1,
                                 r_m_valid, r_m_regwren, r_m_rd);
        w_e2_hit_m = f_src_match(r_e_valid, r_e_rs2_used, r_e_rs2,
                                 r_m_valid, r_m_regwren, r_m_rd);
        w_e1_hit_w = f_src_match(r_e_valid, r_e_rs1_used, r_e_rs1,
                                 r_w_valid, r_w_regwren, r_w_rd);
        w_e2_hit_w = f_src_match(r_e_valid, r_e_rs2_used, r_e_rs2,
                                 r_w_valid, r_w_regwren, r_w_rd);

        fwd_rs1_o = c_FWD_RF;
        fwd_rs2_o = c_FWD_RF;
        if (c_FWD_ON && r_e_valid) begin
            if (w_e1_hit_m) begin
                fwd_rs1_o = c_FWD_MEM;
            end else if (w_e1_hit_w) begin
                fwd_rs1_o = c_FWD_WB;
            end
            if (w_e2_hit_m) begin
                fwd_rs2_o = c_FWD_MEM;
            end else if (w_e2_hit_w) begin
                fwd_rs2_o = c_FWD_WB;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage tag pipeline
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_e_valid    <= 1'b0;
            r_e_rd       <= 5'd0;
            r_e_regwren  <= 1'b0;
            r_e_memren   <= 1'b0;
            r_e_memwren  <= 1'b0;
            r_e_rs1      <= 5'd0;
            r_e_rs2      <= 5'd0;
            r_e_rs1_used <= 1'b0;
            r_e_rs2_used <= 1'b0;
            r_m_valid    <= 1'b0;
            r_m_rd       <= 5'd0;
            r_m_regwren  <= 1'b0;
            r_m_memren   <= 1'b0;
            r_m_memwren  <= 1'b0;
            r_w_valid    <= 1'b0;
            r_w_rd       <= 5'd0;
            r_w_regwren  <= 1'b0;
            r_w_memren   <= 1'b0;
            r_w_memwren  <= 1'b0;
        end else if (!w_freeze) begin
            // M and W always advance when not frozen
            r_m_valid   <= r_e_valid;
            r_m_rd      <= r_e_rd;
            r_m_regwren <= r_e_regwren;
            r_m_memren  <= r_e_memren;
            r_m_memwren <= r_e_memwren;
            r_w_valid   <= r_m_valid;
            r_w_rd      <= r_m_rd;
            r_w_regwren <= r_m_regwren;
            r_w_memren  <= r_m_memren;
            r_w_memwren <= r_m_memwren;

            if (w_br_flush || w_raw_act) begin
                // Bubble into E; fields cleared so a bubble can never match
                r_e_valid    <= 1'b0;
                r_e_rd       <= 5'd0;
                r_e_regwren  <= 1'b0;
                r_e_memren   <= 1'b0;
                r_e_memwren  <= 1'b0;
                r_e_rs1      <= 5'd0;
                r_e_rs2      <= 5'd0;
                r_e_rs1_used <= 1'b0;
                r_e_rs2_used <= 1'b0;
            end else begin
                r_e_valid    <= d_valid_i;
                r_e_rd       <= d_rd_i;
                r_e_regwren  <= d_regwren_i;
                r_e_memren   <= d_memren_i;
                r_e_memwren  <= d_memwren_i;
                r_e_rs1      <= d_rs1_i;
                r_e_rs2      <= d_rs2_i;
                r_e_rs1_used <= d_rs1_used_i;
                r_e_rs2_used <= d_rs2_used_i;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Performance counters (saturating). A cycle that is both frozen and
    // RAW-stalled is one held cycle of the front end and counts once.
    // ------------------------------------------------------------------------
    logic w_stall_evt;

    always_comb begin
        w_stall_evt = w_freeze | w_raw_act;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            end
            if (w_br_flush && (r_flush_cnt != c_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
            end
        end
    end

    always_comb begin
        stall_cnt_o = r_stall_cnt;
        flush_cnt_o = r_flush_cnt;
    end

    // W-stage memory flags travel with the tag but nothing downstream of
    // writeback needs them.
    logic w_unused_wb;
    always_comb begin
        w_unused_wb = r_w_memren | r_w_memwren;
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Self-checking bench for pipe_hazard_ctrl. Two instances share
//               the stimulus: one with forwarding (32-bit counters) and one
//               stall-only (2-bit counters, so saturation is reachable).
//               Each driven cycle pushes its expected outputs to a queue; a
//               monitor on the falling edge pops and compares them.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam logic [3:0] c_NONE   = 4'b0000;  // {stall_f, stall_d, flush_d, flush_e}
    localparam logic [3:0] c_RAW    = 4'b1101;
    localparam logic [3:0] c_FLUSH  = 4'b0011;
    localparam logic [3:0] c_FREEZE = 4'b1100;
    localparam logic       c_SEL_F  = 1'b0;     // forwarding instance
    localparam logic       c_SEL_S  = 1'b1;     // stall-only instance

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        logic       st;
    } dec_t;

    typedef struct packed {
        logic [15:0] id;
        logic        sel;
        logic [3:0]  ctl;
        logic [1:0]  f1;
        logic [1:0]  f2;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    dec_t dec;
    logic e_brtaken;
    logic dmem_ready;

    logic        f_stall_f, f_stall_d, f_flush_d, f_flush_e;
    logic [1:0]  f_fwd1, f_fwd2;
    logic [31:0] f_scnt, f_fcnt;
    logic        s_stall_f, s_stall_d, s_flush_d, s_flush_e;
    logic [1:0]  s_fwd1, s_fwd2;
    logic [1:0]  s_scnt, s_fcnt;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc_id   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.FWD_EN(1), .CNT_W(32)) u_dut_f (
        .clk(clk), .reset(reset),
        .d_valid_i(dec.v), .d_rs1_i(dec.rs1), .d_rs2_i(dec.rs2),
        .d_rs1_used_i(dec.u1), .d_rs2_used_i(dec.u2), .d_rd_i(dec.rd),
        .d_regwren_i(dec.wr), .d_memren_i(dec.ld), .d_memwren_i(dec.st),
        .e_brtaken_i(e_brtaken), .dmem_ready_i(dmem_ready),
        .stall_f_o(f_stall_f), .stall_d_o(f_stall_d),
        .flush_d_o(f_flush_d), .flush_e_o(f_flush_e),
        .fwd_rs1_o(f_fwd1), .fwd_rs2_o(f_fwd2),
        .stall_cnt_o(f_scnt), .flush_cnt_o(f_fcnt)
    );

    pipe_hazard_ctrl #(.FWD_EN(0), .CNT_W(2)) u_dut_s (
        .clk(clk), .reset(reset),
        .d_valid_i(dec.v), .d_rs1_i(dec.rs1), .d_rs2_i(dec.rs2),
        .d_rs1_used_i(dec.u1), .d_rs2_used_i(dec.u2), .d_rd_i(dec.rd),
        .d_regwren_i(dec.wr), .d_memren_i(dec.ld), .d_memwren_i(dec.st),
        .e_brtaken_i(e_brtaken), .dmem_ready_i(dmem_ready),
        .stall_f_o(s_stall_f), .stall_d_o(s_stall_d),
        .flush_d_o(s_flush_d), .flush_e_o(s_flush_e),
        .fwd_rs1_o(s_fwd1), .fwd_rs2_o(s_fwd2),
        .stall_cnt_o(s_scnt), .flush_cnt_o(s_fcnt)
    );

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: compare the outputs of the instance the entry targets
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [3:0]  ctl;
            logic [1:0]  f1, f2;
            logic [31:0] sc, fc;
            e = sb.pop_front();
            if (e.sel == c_SEL_F) begin
                ctl = {f_stall_f, f_stall_d, f_flush_d, f_flush_e};
                f1 = f_fwd1; f2 = f_fwd2; sc = f_scnt; fc = f_fcnt;
            end else begin
                ctl = {s_stall_f, s_stall_d, s_flush_d, s_flush_e};
                f1 = s_fwd1; f2 = s_fwd2;
                sc = {30'd0, s_scnt}; fc = {30'd0, s_fcnt};
            end
            chk($sformatf("ctl#%0d", e.id),  {28'd0, ctl}, {28'd0, e.ctl});
            chk($sformatf("fwd1#%0d", e.id), {30'd0, f1},  {30'd0, e.f1});
            chk($sformatf("fwd2#%0d", e.id), {30'd0, f2},  {30'd0, e.f2});
            chk($sformatf("scnt#%0d", e.id), sc, e.sc);
            chk($sformatf("fcnt#%0d", e.id), fc, e.fc);
        end
    end

    // ------------------------------------------------------------------------
    // Instruction builders
    // ------------------------------------------------------------------------
    function automatic dec_t i_idle();
        return '0;
    endfunction
    function automatic dec_t i_alu(input logic [4:0] rd, rs1, rs2);
        dec_t d = '0;
        d.v = 1'b1; d.rd = rd; d.rs1 = rs1; d.rs2 = rs2;
        d.u1 = 1'b1; d.u2 = 1'b1; d.wr = 1'b1;
        return d;
    endfunction
    function automatic dec_t i_ld(input logic [4:0] rd, rs1);
        dec_t d = '0;
        d.v = 1'b1; d.rd = rd; d.rs1 = rs1; d.u1 = 1'b1; d.wr = 1'b1; d.ld = 1'b1;
        return d;
    endfunction
    function automatic dec_t i_st(input logic [4:0] rs1, rs2);
        dec_t d = '0;
        d.v = 1'b1; d.rs1 = rs1; d.rs2 = rs2; d.u1 = 1'b1; d.u2 = 1'b1; d.st = 1'b1;
        return d;
    endfunction
    function automatic dec_t i_br(input logic [4:0] rs1, rs2);
        dec_t d = '0;
        d.v = 1'b1; d.rs1 = rs1; d.rs2 = rs2; d.u1 = 1'b1; d.u2 = 1'b1;
        return d;
    endfunction

    // ------------------------------------------------------------------------
    // One cycle: drive inputs just after the rising edge, push expectation
    // ------------------------------------------------------------------------
    task automatic cyc(input dec_t d, input logic br, input logic rdy,
                       input logic sel, input logic [3:0] ctl,
                       input logic [1:0] f1, input logic [1:0] f2,
                       input int sc, input int fc);
        exp_t e;
        dec = d; e_brtaken = br; dmem_ready = rdy;
        cyc_id++;
        e.id = 16'(cyc_id); e.sel = sel; e.ctl = ctl; e.f1 = f1; e.f2 = f2;
        e.sc = 32'(sc); e.fc = 32'(fc);
        sb.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; dec = i_idle(); e_brtaken = 1'b0; dmem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        reset = 1'b1; dec = '0; e_brtaken = 1'b0; dmem_ready = 1'b1;
        @(posedge clk); #1;

        // Load-use with forwarding: one bubble, then WB forward
        do_reset();
        cyc(i_ld(5, 1),     0, 1, c_SEL_F, c_NONE, 2'b00, 2'b00, 0, 0);
        cyc(i_alu(6, 5, 7), 0, 1, c_SEL_F, c_RAW,  2'b00, 2'b00, 0, 0);
        cyc(i_alu(6, 5, 7), 0, 1, c_SEL_F, c_NONE, 2'b00, 2'b00, 1, 0);
        cyc(i_idle(),       0, 1, c_SEL_F, c_NONE, 2'b10, 2'b00, 1, 0);

        // Back-to-back ALU forwarding, nop-separated, M-over-W priority, x0
        do_reset();
        cyc(i_alu(5, 1, 2), 0, 1, c_SEL_F, c_NONE, 2'b00, 2'b00, 0, 0);
        cyc(i_alu(8, 5, 5), 0, 1, c_SEL_F, c_NONE, 2'b00, 2'b00, 0, 0);
        cyc(i_idle(),       0, 1, c_SEL_F, c_NONE, 2'b01, 2'b01, 0, 0);
        cyc(i_alu(5, 1, 2), 0, 1, c_SEL_F, c_NONE, 2'b00, 2'b00, 0, 0);
        cyc(i_idle(),       0, 1, c_SEL_F, c_NONE, 2'b00, 2'b00, 0, 0);
        cyc(i_alu(8, 5, 5), 0, 1, c_SEL_F, c_NONE, 2'b00, 2'b00, 0, 0);
        cyc(i_idle(),       0, 1, c_SEL_F, c_NONE, 2'b10, 2'b10, 0, 0);
        cyc(i_alu(5, 1, 2), 0, 1, c_SEL_F, c_NONE, 2'b00, 2'b00, 0, 0);
        cyc(i_alu(5, 3, 4), 0, 1, c_SEL_F, c_NONE, 2'b00, 2'b00, 0, 0);
        cyc(i_alu(8, 5, 6), 0, 1, c_SEL_F, c_NONE, 2'b00, 2'b00, 0, 0);
        cyc(i_idle(),       0, 1, c_SEL_F, c_NONE, 2'b01, 2'b00, 0, 0);
        cyc(i_ld(0, 1),     0, 1, c_SEL_F, c_NONE, 2'b00, 2'b00, 0, 0);
        cyc(i_alu(6, 0, 0), 0, 1, c_SEL_F, c_NONE, 2'b00, 2'b00, 0, 0);
        cyc(i_idle(),       0, 1, c_SEL_F, c_NONE, 2'b00, 2'b00, 0, 0);

        // Stall-only interlock: two bubbles, no forwarding, counter saturation
        do_reset();
        cyc(i_alu(5, 1, 2), 0, 1, c_SEL_S, c_NONE, 2'b00, 2'b00, 0, 0);
        cyc(i_alu(6, 5, 0), 0, 1, c_SEL_S, c_RAW,  2'b00, 2'b00, 0, 0);
        cyc(i_alu(6, 5, 0), 0, 1, c_SEL_S, c_RAW,  2'b00, 2'b00, 1, 0);
        cyc(i_alu(6, 5, 0), 0, 1, c_SEL_S, c_NONE, 2'b00, 2'b00, 2, 0);
        cyc(i_idle(),       0, 1, c_SEL_S, c_NONE, 2'b00, 2'b00, 2, 0);
        cyc(i_alu(7, 6, 0), 0, 1, c_SEL_S, c_RAW,  2'b00, 2'b00, 2, 0);
        cyc(i_alu(7, 6, 0), 0, 1, c_SEL_S, c_NONE, 2'b00, 2'b00, 3, 0);
        cyc(i_alu(9, 7, 0), 0, 1, c_SEL_S, c_RAW,  2'b00, 2'b00, 3, 0);
        cyc(i_alu(9, 7, 0), 0, 1, c_SEL_S, c_RAW,  2'b00, 2'b00, 3, 0);
        cyc(i_alu(9, 7, 0), 0, 1, c_SEL_S, c_NONE, 2'b00, 2'b00, 3, 0);

        // Taken branch flush; branch with bubble in E; flush beats load-use
        do_reset();
        cyc(i_br(1, 2),     0, 1, c_SEL_F, c_NONE,  2'b00, 2'b00, 0, 0);
        cyc(i_ld(3, 4),     1, 1, c_SEL_F, c_FLUSH, 2'b00, 2'b00, 0, 0);
        cyc(i_idle(),       1, 1, c_SEL_F, c_NONE,  2'b00, 2'b00, 0, 1);
        cyc(i_ld(5, 1),     0, 1, c_SEL_F, c_NONE,  2'b00, 2'b00, 0, 1);
        cyc(i_alu(6, 5, 5), 1, 1, c_SEL_F, c_FLUSH, 2'b00, 2'b00, 0, 1);
        cyc(i_idle(),       0, 1, c_SEL_F, c_NONE,  2'b00, 2'b00, 0, 2);

        // Store freeze defers a taken branch; forwarding holds while frozen
        do_reset();
        cyc(i_alu(5, 1, 2), 0, 1, c_SEL_F, c_NONE,   2'b00, 2'b00, 0, 0);
        cyc(i_st(1, 2),     0, 1, c_SEL_F, c_NONE,   2'b00, 2'b00, 0, 0);
        cyc(i_br(5, 5),     0, 1, c_SEL_F, c_NONE,   2'b00, 2'b00, 0, 0);
        cyc(i_ld(9, 1),     1, 0, c_SEL_F, c_FREEZE, 2'b10, 2'b10, 0, 0);
        cyc(i_ld(9, 1),     1, 0, c_SEL_F, c_FREEZE, 2'b10, 2'b10, 1, 0);
        cyc(i_ld(9, 1),     1, 0, c_SEL_F, c_FREEZE, 2'b10, 2'b10, 2, 0);
        cyc(i_ld(9, 1),     1, 1, c_SEL_F, c_FLUSH,  2'b10, 2'b10, 3, 0);
        cyc(i_idle(),       0, 0, c_SEL_F, c_NONE,   2'b00, 2'b00, 3, 1);

        // Reset asserted in the middle of a freeze
        do_reset();
        cyc(i_st(1, 2),     0, 1, c_SEL_F, c_NONE,   2'b00, 2'b00, 0, 0);
        cyc(i_idle(),       0, 1, c_SEL_F, c_NONE,   2'b00, 2'b00, 0, 0);
        cyc(i_idle(),       0, 0, c_SEL_F, c_FREEZE, 2'b00, 2'b00, 0, 0);
        cyc(i_idle(),       0, 0, c_SEL_F, c_FREEZE, 2'b00, 2'b00, 1, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        cyc(i_idle(),       1, 0, c_SEL_F, c_NONE,   2'b00, 2'b00, 0, 0);
        cyc(i_idle(),       1, 0, c_SEL_S, c_NONE,   2'b00, 2'b00, 0, 0);

        // Every pushed expectation must have been consumed by the monitor
        for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: FWD_EN, default 1, meaning 1 = EX/WB forwarding enabled, 0 = stall-only interlock.
REQ-002 Parameter: CNT_W, default 32, meaning width of the stall and flush performance counters.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 d_valid_i  input  1  decode stage holds a real instruction.
REQ-006 d_rs1_i, d_rs2_i  input  5 each  decode source register indices.
REQ-007 d_rs1_used_i, d_rs2_used_i  input  1 each  the decode instruction reads that source.
REQ-008 d_rd_i  input  5  decode destination register index.
REQ-009 d_regwren_i, d_memren_i, d_memwren_i  input  1 each  decode register-write, load and store flags.
REQ-010 e_brtaken_i  input  1  the execute-stage instruction redirects the PC (taken branch, JAL or JALR).
REQ-011 dmem_ready_i  input  1  data memory completes the memory-stage access this cycle.
REQ-012 stall_f_o, stall_d_o  output  1 each  hold the PC and the decode register.
REQ-013 flush_d_o, flush_e_o  output  1 each  squash decode and insert a bubble into execute.
REQ-014 fwd_rs1_o, fwd_rs2_o  output  2 each  execute operand source: 00 = register file, 01 = memory-stage ALU result, 10 = writeback data.
REQ-015 stall_cnt_o, flush_cnt_o  output  CNT_W each  performance counters.

Function
REQ-016 The block SHALL hold a tag per stage for E, M and W: valid, rd, regwren, memren, memwren, plus rs1/rs2 and their used flags for E only.
REQ-017 freeze = M.valid & (M.memren | M.memwren) & ~dmem_ready_i.
REQ-018 Under freeze: all tags hold, stall_f_o = stall_d_o = 1, flush_d_o = flush_e_o = 0, and the fwd outputs stay unchanged.
REQ-019 When not frozen and E.valid & e_brtaken_i: flush_d_o = flush_e_o = 1 and stall_f_o = stall_d_o = 0; next E = bubble, M <= E, W <= M.
REQ-020 When not frozen, not flushing, and raw_stall: stall_f_o = stall_d_o = 1 and flush_e_o = 1; next E = bubble, M <= E, W <= M.
REQ-021 Otherwise all stages advance: E <= decode tag (valid = d_valid_i), M <= E, W <= M; all stall and flush outputs are 0.
REQ-022 Priority SHALL be freeze > branch flush > raw_stall > advance.
REQ-023 A source matches a stage if: d_valid_i, the used flag is set, stage.valid, stage.regwren, stage.rd != 0, and stage.rd == rs.
REQ-024 With FWD_EN=1: raw_stall = match against E where E.memren (load-use only); one bubble per load-use.
REQ-025 With FWD_EN=0: raw_stall = match against E or M, regardless of instruction type. The register file is write-first, so W is never a hazard.
REQ-026 fwd_rsN_o SHALL be 01 if the E source matches M, else 10 if it matches W, else 00. Matching uses the same rules as REQ-023 with E as the consumer. M priority exceeds W.
REQ-027 fwd outputs SHALL be combinational from the registered tags and forced to 00 when FWD_EN=0 or E.valid=0.
REQ-028 Register x0 SHALL never cause a stall or a forward.
REQ-029 stall_cnt_o SHALL increment on each cycle with freeze or raw_stall (counted once when both apply).
REQ-030 flush_cnt_o SHALL increment on each branch-flush cycle.
REQ-031 Both counters SHALL saturate at all-ones.
REQ-032 A taken branch during freeze SHALL be deferred: E holds, so e_brtaken_i is re-evaluated in the first unfrozen cycle.

Reset
REQ-033 While reset=1 at a clock edge: all stage valid bits cleared and both counters set to 0.
REQ-034 From the cycle after reset: outputs read stall/flush = 0 and fwd = 00.
REQ-035 Reset SHALL override freeze, flush and stall when asserted mid-operation; no partial state is retained.

Verification
REQ-036 FWD_EN=1; lw x5 in E, decode add x6,x5,x7 -> stall_f/stall_d/flush_e = 1 for exactly 1 cycle; next cycle E holds the add with fwd_rs1_o = 10; stall_cnt_o = 1.
REQ-037 FWD_EN=1; add x5 then sub x8,x5,x5 back-to-back -> no stall; the sub in E sees fwd_rs1_o = fwd_rs2_o = 01. One cycle later with an intervening nop, fwd = 10.
REQ-038 FWD_EN=0; add x5 then add x6,x5,x0 -> 2 stall cycles; fwd always 00; stall_cnt_o = 2.
REQ-039 Taken beq in E while decode holds lw x3 -> flush_d_o = flush_e_o = 1 for 1 cycle, no stall; flush_cnt_o = 1.
REQ-040 sw in M with dmem_ready_i low for 3 cycles and e_brtaken_i high -> 3 frozen cycles, no flush; flush fires on the 4th cycle; stall_cnt_o = 3.
REQ-041 Writer rd = x0 followed by a reader of x0 -> no stall, fwd = 00.
REQ-042 Reset asserted during a freeze -> the next cycle shows all outputs 0 and counters 0.
